sprite_bitmap_loader: RTL and testbench

- Writer side of the sprite bitmap memory interface: a sprite RAM plus a byte-stream loader that fills it at runtime.
- Replaces a fixed bitmap ROM, so tank/sprite graphics can be downloaded by a CPU or test harness.
- Its read port is drop-in for the renderer's rom_addr/rom_bits fetch: address in one cycle, data registered the next.
- Load writes are held off while the renderer is busy, so a sprite row never tears mid-scanline.

---
 rtl/sprite_bitmap_loader.sv | 132 +++++++++++++
 tb/tb_sprite_bitmap_loader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_bitmap_loader.sv
// Sprite bitmap RAM with a byte-stream loader on the write side.
// Read port is a drop-in for a registered bitmap ROM fetch.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   cmd_start     one-cycle pulse that starts a load
//   cmd_base      first RAM byte address of the load
//   cmd_len       byte count, 0..2^ADDR_WIDTH
//   load_valid    load_data holds a byte
//   load_data     bitmap byte (even addr = row[7:0], odd = row[15:8])
//   load_ready    loader accepts a byte this cycle
//   render_busy   renderer busy; holds off writes when gating is on
//   rd_addr       renderer fetch address
//   rd_bits       registered read data, one cycle after rd_addr
//   busy          load in progress
//   done          one-cycle pulse when a load completes
//   cmd_error     one-cycle pulse when a cmd_start was rejected
module sprite_bitmap_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter bit GATE_ON_RENDER = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic                  load_valid,
  input  logic [7:0]            load_data,
  output logic                  load_ready,
  input  logic                  render_busy,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_bits,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_nxt;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   remaining_nxt;
  logic                  err_q;
  logic                  err_nxt;
  logic                  xfer;
  logic                  reject;

  logic [7:0] ram [DEPTH];

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    remaining_nxt = remaining;
    load_ready    = 1'b0;
    xfer          = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_start) begin
          if (cmd_len != '0) begin
            wr_ptr_nxt    = cmd_base;
            remaining_nxt = cmd_len;
            state_nxt     = LOAD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      LOAD: begin
        load_ready = !GATE_ON_RENDER || !render_busy;
        xfer       = load_valid && load_ready;
        if (xfer) begin
          wr_ptr_nxt    = wr_ptr + 1'b1;
          remaining_nxt = remaining - LEN_ONE;
          if (remaining == LEN_ONE) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy   = (state == LOAD);
  assign done   = (state == DONE);
  assign reject = cmd_start && (state != IDLE);

  // A reject landing on the final byte would collide with the
  // done pulse; hold it one more cycle so the two never overlap.
  assign err_nxt   = reject || (err_q && done);
  assign cmd_error = err_q && !done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
      err_q     <= 1'b0;
      rd_bits   <= '0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      remaining <= remaining_nxt;
      err_q     <= err_nxt;
      rd_bits   <= ram[rd_addr];
    end
  end

  // No reset on the array: contents survive an aborted load.
  // The reset term stops a byte landing on the abort edge.
  always_ff @(posedge clk) begin
    if (xfer && !reset) begin
      ram[wr_ptr] <= load_data;
    end
  end

endmodule

// File: tb/tb_sprite_bitmap_loader.sv
// Randomized scoreboard bench for sprite_bitmap_loader.
// Reference model: byte array plus event/readback queues.
module tb_sprite_bitmap_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_start = 1'b0;
  logic [7:0] cmd_base = '0;
  logic [8:0] cmd_len = '0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_ready;
  logic       render_busy = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_bits;
  logic       busy;
  logic       done;
  logic       cmd_error;

  sprite_bitmap_loader #(
    .ADDR_WIDTH(8),
    .GATE_ON_RENDER(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_start(cmd_start),
    .cmd_base(cmd_base),
    .cmd_len(cmd_len),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .render_busy(render_busy),
    .rd_addr(rd_addr),
    .rd_bits(rd_bits),
    .busy(busy),
    .done(done),
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int cyc;
  } ev_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] model [256];
  logic [7:0] ld [$];
  logic [7:0] rdq [$];
  ev_t        evq [$];
  logic       rd_req = 1'b0;
  logic       rd_req_d = 1'b0;
  ev_t        e_m;
  logic [7:0] exp_m;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_req_d <= rd_req;
  end

  // Monitor: compares readback and done/cmd_error pulses
  // against the expectations queued by the stimulus.
  always @(negedge clk) begin
    if (rd_req_d) begin
      if (rdq.size() == 0) begin
        chk("rdq_underflow", 1, 0);
      end else begin
        exp_m = rdq.pop_front();
        chk("rd_bits", rd_bits, exp_m);
      end
    end
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      e_m = evq.pop_front();
      chk(e_m.is_err ? "missed_cmd_error" : "missed_done",
          0, 1);
    end
    if (done && cmd_error) begin
      chk("done_and_error", 1, 0);
    end
    if (!reset && (done || cmd_error)) begin
      if (evq.size() == 0) begin
        chk(done ? "unexpected_done" : "unexpected_cmd_error",
            1, 0);
      end else begin
        e_m = evq.pop_front();
        chk("event_kind", cmd_error, e_m.is_err);
        chk("event_cycle", cyc, e_m.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int a);
    rd_addr = 8'(a);
    rd_req  = 1'b1;
    rdq.push_back(model[a % 256]);
    step();
    rd_req = 1'b0;
  endtask

  task automatic push_ev(input bit is_err, input int c);
    ev_t e;
    e.is_err = is_err;
    e.cyc    = c;
    evq.push_back(e);
  endtask

  // Streams ld[] into base.., holding render_busy for stall_len
  // cycles once stall_after bytes are in. rej_t issues a stray
  // cmd_start on that loop cycle; collide_t reads the address
  // being written on that loop cycle.
  task automatic run_load(input int base, input int len,
                          input int stall_after, input int stall_len,
                          input int rej_t, input int collide_t);
    int c0;
    int t_total;
    int k;
    int s;
    int a;
    int waddr;
    int dcyc;
    int ecyc;
    bit stalled;
    t_total = (stall_after < len) ? len + stall_len : len;
    c0      = cyc;
    dcyc    = c0 + t_total + 1;
    ecyc    = (rej_t == t_total) ? c0 + rej_t + 2 : c0 + rej_t + 1;
    if (rej_t > 0 && ecyc < dcyc) push_ev(1'b1, ecyc);
    push_ev(1'b0, dcyc);
    if (rej_t > 0 && ecyc > dcyc) push_ev(1'b1, ecyc);
    cmd_start = 1'b1;
    cmd_base  = 8'(base);
    cmd_len   = 9'(len);
    step();
    cmd_start = 1'b0;
    cmd_base  = 8'($urandom);
    cmd_len   = 9'($urandom);
    k = 0;
    s = 0;
    for (int t = 1; t <= t_total; t++) begin
      stalled     = (k == stall_after) && (s < stall_len);
      render_busy = stalled;
      load_valid  = 1'b1;
      load_data   = ld[k];
      waddr       = (base + k) % 256;
      if (t == rej_t) begin
        cmd_start = 1'b1;
        cmd_base  = 8'($urandom);
        cmd_len   = 9'($urandom_range(1, 256));
      end
      a = (t == collide_t) ? waddr : int'($urandom_range(0, 255));
      rd_addr = 8'(a);
      rd_req  = 1'b1;
      rdq.push_back(model[a]);
      @(negedge clk);
      chk("load_ready", load_ready, stalled ? 0 : 1);
      chk("busy_in_load", busy, 1);
      step();
      cmd_start = 1'b0;
      if (stalled) begin
        s++;
      end else begin
        model[waddr] = ld[k];
        k++;
      end
    end
    rd_req      = 1'b0;
    load_valid  = 1'b0;
    render_busy = 1'b0;
    @(negedge clk);
    chk("busy_in_done", busy, 0);
    chk("ready_in_done", load_ready, 0);
    step();
  endtask

  task automatic fill_rand(input int n);
    ld.delete();
    for (int i = 0; i < n; i++) ld.push_back(8'($urandom));
  endtask

  initial begin
    int base;
    int len;
    for (int i = 0; i < 256; i++) model[i] = '0;

    // reset state
    step();
    step();
    @(negedge clk);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_error", cmd_error, 0);
    chk("rst_rd_bits", rd_bits, 0);
    step();
    reset = 1'b0;
    step();

    // full-depth load gives the model a known image
    fill_rand(256);
    run_load($urandom_range(0, 255), 256, 256, 0, 0, -1);

    // 32 sequential bytes at 0x00, then read 0x05
    ld.delete();
    for (int i = 0; i < 32; i++) ld.push_back(8'(i));
    run_load(0, 32, 32, 0, 0, -1);
    do_read(5);
    chk("seq_byte5", model[5], 5);

    // render hold after byte 2
    fill_rand(4);
    run_load(8'h40, 4, 2, 10, 0, -1);
    for (int i = 'h40; i < 'h44; i++) do_read(i);

    // wrap from 0xFF to 0x00
    ld.delete();
    ld.push_back(8'hAA);
    ld.push_back(8'h55);
    run_load(8'hFF, 2, 2, 0, 0, -1);
    do_read(8'hFF);
    do_read(8'h00);

    // reject mid-load and on the final byte
    fill_rand(8);
    run_load($urandom_range(0, 255), 8, 8, 0, 4, -1);
    fill_rand(5);
    run_load($urandom_range(0, 255), 5, 2, 3, 8, -1);
    do_read(cyc % 256);

    // zero-length command
    push_ev(1'b0, cyc + 1);
    cmd_start = 1'b1;
    cmd_base  = 8'h20;
    cmd_len   = '0;
    step();
    cmd_start = 1'b0;
    @(negedge clk);
    chk("zero_len_busy", busy, 0);
    step();
    for (int i = 'h20; i < 'h24; i++) do_read(i);

    // reset after byte 3 of 8
    base = $urandom_range(0, 255);
    fill_rand(8);
    cmd_start = 1'b1;
    cmd_base  = 8'(base);
    cmd_len   = 9'd8;
    step();
    cmd_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1;
      load_data  = ld[k];
      step();
      model[(base + k) % 256] = ld[k];
    end
    load_data = ld[3];
    reset     = 1'b1;
    step();
    reset      = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    step();
    for (int k = 0; k < 8; k++) do_read(base + k);

    // read-first collision at 0x10
    ld.delete();
    ld.push_back(8'h11);
    run_load(8'h10, 1, 1, 0, 0, -1);
    ld.delete();
    ld.push_back(8'h22);
    run_load(8'h10, 1, 1, 0, 0, 1);
    do_read(8'h10);

    // randomized loads with stalls, rejects and collisions
    for (int n = 0; n < 30; n++) begin
      int sa;
      int sl;
      int rj;
      int tt;
      len = $urandom_range(1, 24);
      sa  = $urandom_range(0, len);
      sl  = $urandom_range(0, 5);
      tt  = (sa < len) ? len + sl : len;
      rj  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, tt) : 0;
      fill_rand(len);
      run_load($urandom_range(0, 255), len, sa, sl, rj,
               $urandom_range(1, tt));
      for (int r = 0; r < 3; r++) do_read($urandom_range(0, 255));
    end

    step();
    step();
    step();
    chk("events_left", evq.size(), 0);
    chk("reads_left", rdq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
